// File: rtl/segment_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : segment_capture_pkg                                    |
// | Description : Shared seven-segment hex table, frame FSM encodings,   |
// |               digit count and one-hot helpers for the display        |
// |               encoder and the segment_capture decoder.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package segment_capture_pkg;

  // Digits per displayed word.
  localparam int NUM_DIGITS = 4;

  // Hex glyphs, bit6=g .. bit0=a; element n is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Frame FSM encodings.
  localparam logic [0:0] ST_WAIT0   = 1'b0;  // expecting digit 0
  localparam logic [0:0] ST_COLLECT = 1'b1;  // expecting digit 1..3

  // True when exactly one enable bit is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Position of the set bit of a one-hot enable vector.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/segment_capture_seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seg7_decode                                            |
// | Description : Combinational seven-segment pattern to hex nibble      |
// |               lookup; valid is low for patterns outside the table.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module seg7_decode
  import segment_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  // Search the shared glyph table for the incoming pattern.
  always_comb begin
    nibble = 4'd0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i[3:0]]) begin
        nibble = i[3:0];
        valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/segment_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : segment_capture                                        |
// | Description : Recovers a 16-bit hex word from a scanned, multiplexed |
// |               seven-segment display; debounces each digit dwell and  |
// |               assembles digits 0..3 in order into data_out.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module segment_capture
  import segment_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  segment,
  input  logic [3:0]  bytee,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        code_err,
  output logic        seq_err
);

  localparam logic [7:0] SAMPLE_AT = 8'(STABLE_CYCLES - 2);
  localparam logic [7:0] CNT_SAT   = 8'(STABLE_CYCLES);
  localparam logic [1:0] LAST_IDX  = 2'(NUM_DIGITS - 1);

  logic [6:0]  seg_q;
  logic [3:0]  byte_q;
  logic [6:0]  seg_prev;
  logic [3:0]  byte_prev;
  logic [7:0]  stable_cnt;
  logic [0:0]  state;
  logic [1:0]  exp_idx;
  logic [11:0] partial;

  logic        changed;
  logic        take_sample;
  logic [1:0]  digit_idx;
  logic [3:0]  dec_nibble;
  logic        dec_valid;

  // The comparison is made on the registered pair against its previous value;
  // a sample fires on the edge that moves the counter onto STABLE_CYCLES-1,
  // which happens once per dwell because the counter saturates above it.
  assign changed     = {seg_q, byte_q} != {seg_prev, byte_prev};
  assign take_sample = !changed && (stable_cnt == SAMPLE_AT) && is_onehot(byte_q);
  assign digit_idx   = onehot_index(byte_q);

  seg7_decode u_decode (
    .pattern (seg_q),
    .nibble  (dec_nibble),
    .valid   (dec_valid)
  );

  // Input registers and their one-cycle-older copies for change detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      seg_q     <= 7'd0;
      byte_q    <= 4'd0;
      seg_prev  <= 7'd0;
      byte_prev <= 4'd0;
    end else begin
      seg_q     <= segment;
      byte_q    <= bytee;
      seg_prev  <= seg_q;
      byte_prev <= byte_q;
    end
  end

  // Stability counter: restart on any change, otherwise count up and saturate.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stable_cnt <= 8'd0;
    end else if (changed) begin
      stable_cnt <= 8'd0;
    end else if (stable_cnt != CNT_SAT) begin
      stable_cnt <= stable_cnt + 8'd1;
    end
  end

  // Frame assembly FSM with output word and single-cycle status pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_WAIT0;
      exp_idx    <= 2'd0;
      partial    <= 12'd0;
      data_out   <= 16'h0000;
      data_valid <= 1'b0;
      code_err   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      code_err   <= 1'b0;
      seq_err    <= 1'b0;
      if (take_sample) begin
        if (!dec_valid) begin
          code_err <= 1'b1;
          state    <= ST_WAIT0;
          exp_idx  <= 2'd0;
          partial  <= 12'd0;
        end else if (digit_idx == 2'd0) begin
          // Digit 0 always restarts a frame, whatever was in progress.
          partial[3:0] <= dec_nibble;
          exp_idx      <= 2'd1;
          state        <= ST_COLLECT;
        end else if ((state == ST_COLLECT) && (digit_idx == exp_idx)) begin
          if (digit_idx == LAST_IDX) begin
            data_out   <= {dec_nibble, partial};
            data_valid <= 1'b1;
            state      <= ST_WAIT0;
            exp_idx    <= 2'd0;
          end else begin
            partial[{digit_idx, 2'b00} +: 4] <= dec_nibble;
            exp_idx <= exp_idx + 2'd1;
          end
        end else begin
          seq_err <= 1'b1;
          state   <= ST_WAIT0;
          exp_idx <= 2'd0;
          partial <= 12'd0;
        end
      end
    end
  end

endmodule
`default_nettype wire
